// File: rtl/apb_timer_slave_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and the timer slave.
interface apb_timer_slave_if;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata
    );
endinterface

// File: rtl/apb_timer_slave.sv
// APB down-counting timer: 32-bit reloadable counter, expiry flag and level interrupt.
// Define APB_TIMER_PRESCALE_EN to add the PRESC register (offset 4) and the 8-bit tick prescaler.
module apb_timer_slave #(
    parameter int SEL_IDX = 1
) (
    input  logic             Hclk,
    input  logic             Hreset,
    apb_timer_slave_if.slave apb,
    output logic             Irq
);

    localparam logic [1:0] SEL_BIT     = SEL_IDX[1:0];
    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_LOAD   = 3'd1;
    localparam logic [2:0] ADDR_COUNT  = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;

    logic        sel;
    logic        wr_en;
    logic [2:0]  reg_addr;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_status;
    logic        en_q;
    logic        ar_q;
    logic        ie_q;
    logic        exp_q;
    logic [31:0] load_q;
    logic [31:0] count_q;
    logic [31:0] rd_data;
    logic        tick;
    logic        expire;
    logic        en_rise;
    logic        unused_bits;

    assign sel       = apb.Pselx[SEL_BIT];
    assign wr_en     = sel & apb.Penable & apb.Pwrite;
    assign reg_addr  = apb.Paddr[4:2];
    assign wr_ctrl   = wr_en && (reg_addr == ADDR_CTRL);
    assign wr_load   = wr_en && (reg_addr == ADDR_LOAD);
    assign wr_status = wr_en && (reg_addr == ADDR_STATUS);

    assign unused_bits = ^{apb.Pselx, apb.Paddr[31:5], apb.Paddr[1:0]};

    // EN rising through a CTRL write is the only path that loads COUNT from a stopped timer.
    assign en_rise = wr_ctrl && apb.Pwdata[0] && !en_q;
    assign expire  = tick && (count_q == 32'd0);

`ifdef APB_TIMER_PRESCALE_EN
    localparam logic [2:0] ADDR_PRESC = 3'd4;

    logic       wr_presc;
    logic [7:0] presc_q;
    logic [7:0] pcnt_q;

    assign wr_presc = wr_en && (reg_addr == ADDR_PRESC);
    // Compare with >= so lowering PRESC mid-run cannot strand the counter past its terminal value.
    assign tick     = en_q && (pcnt_q >= presc_q);

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            presc_q <= 8'd0;
            pcnt_q  <= 8'd0;
        end else begin
            if (wr_presc) begin
                presc_q <= apb.Pwdata[7:0];
            end
            if (!en_q || tick) begin
                pcnt_q <= 8'd0;
            end else begin
                pcnt_q <= pcnt_q + 8'd1;
            end
        end
    end
`else
    assign tick = en_q;
`endif

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            ie_q    <= 1'b0;
            exp_q   <= 1'b0;
            load_q  <= 32'd0;
            count_q <= 32'd0;
        end else begin
            if (wr_load) begin
                load_q <= apb.Pwdata;
            end

            if (en_rise) begin
                count_q <= load_q;
            end else if (tick) begin
                if (count_q != 32'd0) begin
                    count_q <= count_q - 32'd1;
                end else if (ar_q) begin
                    count_q <= load_q;
                end
            end

            // A CTRL write overrides the one-shot self-disable in the same cycle.
            if (wr_ctrl) begin
                en_q <= apb.Pwdata[0];
                ar_q <= apb.Pwdata[1];
                ie_q <= apb.Pwdata[2];
            end else if (expire && !ar_q) begin
                en_q <= 1'b0;
            end

            if (expire) begin
                exp_q <= 1'b1;
            end else if (wr_status && apb.Pwdata[0]) begin
                exp_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (reg_addr)
            ADDR_CTRL:   rd_data = {29'd0, ie_q, ar_q, en_q};
            ADDR_LOAD:   rd_data = load_q;
            ADDR_COUNT:  rd_data = count_q;
            ADDR_STATUS: rd_data = {31'd0, exp_q};
`ifdef APB_TIMER_PRESCALE_EN
            ADDR_PRESC:  rd_data = {24'd0, presc_q};
`endif
            default:     rd_data = 32'd0;
        endcase
    end

    assign apb.Prdata = (sel && !apb.Pwrite) ? rd_data : 32'd0;
    assign Irq        = exp_q & ie_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: directed scenarios plus randomized runs
// checked against an arithmetic model of tick count versus time since enable.
module tb_apb_timer_slave;

    localparam logic [2:0] MY_SEL = 3'b010;
`ifdef APB_TIMER_PRESCALE_EN
    localparam bit PRESC_ON = 1'b1;
`else
    localparam bit PRESC_ON = 1'b0;
`endif

    logic Hclk;
    logic Hreset;
    logic Irq;
    int   checks;
    int   fails;

    apb_timer_slave_if bus ();

    apb_timer_slave #(.SEL_IDX(1)) dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .apb    (bus.slave),
        .Irq    (Irq)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model: n edges after the enable edge, t = n/P ticks have happened.
    function automatic logic [31:0] model_count(int unsigned ld, bit ar, int unsigned p, int unsigned n);
        int unsigned t;
        t = n / p;
        if (ar) return 32'(ld - (t % (ld + 1)));
        return (t >= ld) ? 32'd0 : 32'(ld - t);
    endfunction

    function automatic bit model_exp(int unsigned ld, int unsigned p, int unsigned n);
        return n >= (ld + 1) * p;
    endfunction

    function automatic bit model_en(int unsigned ld, bit ar, int unsigned p, int unsigned n);
        return ar || (n < (ld + 1) * p);
    endfunction

    task automatic bus_idle();
        bus.Pselx   = 3'b000;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b0;
        bus.Paddr   = 32'd0;
        bus.Pwdata  = 32'd0;
    endtask

    task automatic set_addr(input logic [2:0] idx);
        logic [26:0] hi;
        logic [1:0]  lo;
        hi = 27'($urandom());
        lo = 2'($urandom());
        bus.Paddr = {hi, idx, lo};
    endtask

    // Caller sits at a negedge; the access edge is the second posedge after the call.
    task automatic apb_write(input logic [2:0] idx, input logic [31:0] data);
        bus.Pselx   = MY_SEL;
        bus.Pwrite  = 1'b1;
        bus.Penable = 1'b0;
        bus.Pwdata  = data;
        set_addr(idx);
        @(negedge Hclk);
        bus.Penable = 1'b1;
        @(negedge Hclk);
        bus_idle();
    endtask

    task automatic apb_read(input logic [2:0] lines, input logic [2:0] idx, output logic [31:0] data);
        bus.Pselx   = lines;
        bus.Pwrite  = 1'b0;
        bus.Penable = 1'b0;
        set_addr(idx);
        @(negedge Hclk);
        bus.Penable = 1'b1;
        #1 data = bus.Prdata;
        @(negedge Hclk);
        bus_idle();
    endtask

    // Setup-phase snoop within the low clock phase; no edge passes.
    task automatic peek(input logic [2:0] idx, output logic [31:0] data);
        bus.Pselx   = MY_SEL;
        bus.Pwrite  = 1'b0;
        bus.Penable = 1'b0;
        set_addr(idx);
        #1 data = bus.Prdata;
        bus_idle();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        apb_write(3'd4, 32'd2);
        apb_write(3'd1, 32'd5);
        apb_write(3'd0, 32'd7);
        repeat (20) @(negedge Hclk);
        Hreset = 1'b1;
        repeat (2) @(negedge Hclk);
        for (int i = 0; i < 5; i++) begin
            peek(3'(i), d);
            checks++;
            if (d !== 32'd0) begin
                fails++;
                $display("[TB] FAIL reset_reg%0d: got %h expected 00000000", i, d);
            end
        end
        checks++;
        if (Irq !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_irq: got %b expected 0", Irq);
        end
        #1;
        checks++;
        if (bus.Prdata !== 32'd0) begin
            fails++;
            $display("[TB] FAIL reset_prdata_unselected: got %h expected 00000000", bus.Prdata);
        end
        Hreset = 1'b0;
        @(negedge Hclk);
        peek(3'd3, d);
        checks++;
        if (d !== 32'd0) begin
            fails++;
            $display("[TB] FAIL reset_status_after_release: got %h expected 00000000", d);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        apb_write(3'd4, 32'd0);
        apb_write(3'd1, 32'd3);
        apb_write(3'd0, 32'h5);
        repeat (3) @(negedge Hclk);
        peek(3'd3, d);
        checks++;
        if (d !== 32'd0 || Irq !== 1'b0) begin
            fails++;
            $display("[TB] FAIL one_shot_early: status %h irq %b, expected 00000000 and 0", d, Irq);
        end
        @(negedge Hclk);
        peek(3'd3, d);
        checks++;
        if (d !== 32'd1 || Irq !== 1'b1) begin
            fails++;
            $display("[TB] FAIL one_shot_expire: status %h irq %b, expected 00000001 and 1", d, Irq);
        end
        peek(3'd0, d);
        checks++;
        if (d !== 32'h4) begin
            fails++;
            $display("[TB] FAIL one_shot_ctrl: got %h expected 00000004", d);
        end
        repeat (3) @(negedge Hclk);
        peek(3'd2, d);
        checks++;
        if (d !== 32'd0) begin
            fails++;
            $display("[TB] FAIL one_shot_count_hold: got %h expected 00000000", d);
        end
        apb_write(3'd3, 32'hFFFF_FFFE);
        peek(3'd3, d);
        checks++;
        if (d !== 32'd1) begin
            fails++;
            $display("[TB] FAIL status_write0: got %h expected 00000001", d);
        end
    endtask

    task automatic test_auto_reload_w1c();
        logic [31:0] d;
        apb_write(3'd0, 32'd0);
        apb_write(3'd3, 32'd1);
        apb_write(3'd4, 32'd0);
        apb_write(3'd1, 32'd2);
        apb_write(3'd0, 32'h7);
        repeat (2) @(negedge Hclk);
        peek(3'd3, d);
        checks++;
        if (d !== 32'd0) begin
            fails++;
            $display("[TB] FAIL ar_before_expiry: got %h expected 00000000", d);
        end
        @(negedge Hclk);
        peek(3'd3, d);
        checks++;
        if (d !== 32'd1 || Irq !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ar_first_expiry: status %h irq %b, expected 00000001 and 1", d, Irq);
        end
        @(negedge Hclk);
        apb_write(3'd3, 32'd1);
        peek(3'd3, d);
        checks++;
        if (d !== 32'd1 || Irq !== 1'b1) begin
            fails++;
            $display("[TB] FAIL w1c_on_expiry: status %h irq %b, expected 00000001 and 1", d, Irq);
        end
        apb_write(3'd3, 32'd1);
        peek(3'd3, d);
        checks++;
        if (d !== 32'd0 || Irq !== 1'b0) begin
            fails++;
            $display("[TB] FAIL w1c_clear: status %h irq %b, expected 00000000 and 0", d, Irq);
        end
        peek(3'd2, d);
        checks++;
        if (d !== 32'd0) begin
            fails++;
            $display("[TB] FAIL ar_count: got %h expected 00000000", d);
        end
        @(negedge Hclk);
        peek(3'd3, d);
        checks++;
        if (d !== 32'd1 || Irq !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ar_reexpiry: status %h irq %b, expected 00000001 and 1", d, Irq);
        end
        apb_write(3'd0, 32'd0);
    endtask

    task automatic test_decode();
        logic [31:0] d;
        apb_write(3'd0, 32'd0);
        apb_write(3'd4, 32'd0);
        apb_write(3'd1, 32'hDEAD_BEEF);
        apb_read(MY_SEL, 3'd1, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            fails++;
            $display("[TB] FAIL load_readback: got %h expected deadbeef", d);
        end
        apb_read(3'b101, 3'd1, d);
        checks++;
        if (d !== 32'd0) begin
            fails++;
            $display("[TB] FAIL other_select: got %h expected 00000000", d);
        end
        apb_write(3'd1, 32'd9);
        apb_write(3'd0, 32'd1);
        apb_write(3'd0, 32'd0);
        apb_write(3'd2, 32'h0000_1234);
        peek(3'd2, d);
        checks++;
        if (d !== 32'd7) begin
            fails++;
            $display("[TB] FAIL count_readonly: got %h expected 00000007", d);
        end
        bus.Pselx  = MY_SEL;
        bus.Pwrite = 1'b1;
        bus.Pwdata = 32'h55;
        set_addr(3'd1);
        @(negedge Hclk);
        bus_idle();
        peek(3'd1, d);
        checks++;
        if (d !== 32'd9) begin
            fails++;
            $display("[TB] FAIL setup_only_write: got %h expected 00000009", d);
        end
        for (int i = 5; i < 8; i++) begin
            apb_write(3'(i), 32'hFFFF_FFFF);
            apb_read(MY_SEL, 3'(i), d);
            checks++;
            if (d !== 32'd0) begin
                fails++;
                $display("[TB] FAIL reserved_%0d: got %h expected 00000000", i, d);
            end
        end
        apb_write(3'd0, 32'hFFFF_FFF8);
        apb_read(MY_SEL, 3'd0, d);
        checks++;
        if (d !== 32'd0) begin
            fails++;
            $display("[TB] FAIL ctrl_upper_bits: got %h expected 00000000", d);
        end
    endtask

    task automatic test_prescaler();
        logic [31:0] d;
        int unsigned exp_n;
        apb_write(3'd0, 32'd0);
        apb_write(3'd3, 32'd1);
        apb_write(3'd4, 32'd3);
        peek(3'd4, d);
        checks++;
        if (d !== (PRESC_ON ? 32'd3 : 32'd0)) begin
            fails++;
            $display("[TB] FAIL presc_readback: got %h expected %h", d, PRESC_ON ? 32'd3 : 32'd0);
        end
        exp_n = 2 * (PRESC_ON ? 4 : 1);
        apb_write(3'd1, 32'd1);
        apb_write(3'd0, 32'd1);
        repeat (exp_n - 1) @(negedge Hclk);
        peek(3'd3, d);
        checks++;
        if (d !== 32'd0) begin
            fails++;
            $display("[TB] FAIL presc_before_expiry: got %h expected 00000000", d);
        end
        @(negedge Hclk);
        peek(3'd3, d);
        checks++;
        if (d !== 32'd1) begin
            fails++;
            $display("[TB] FAIL presc_expiry: got %h expected 00000001", d);
        end
        apb_write(3'd0, 32'd0);
        apb_write(3'd4, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] want;
        for (int it = 0; it < 5; it++) begin
            int unsigned ld;
            int unsigned ps;
            int unsigned p;
            int unsigned span;
            bit ar;
            bit ie;
            bit e;
            ld = $urandom_range(0, 6);
            ps = $urandom_range(0, 2);
            ar = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            p  = PRESC_ON ? ps + 1 : 1;
            apb_write(3'd0, 32'd0);
            apb_write(3'd3, 32'd1);
            apb_write(3'd4, 32'(ps));
            apb_write(3'd1, 32'(ld));
            apb_write(3'd0, {29'd0, ie, ar, 1'b1});
            span = 2 * (ld + 1) * p + 1;
            for (int n = 0; n <= int'(span); n++) begin
                e = model_exp(ld, p, n);
                peek(3'd2, d);
                want = model_count(ld, ar, p, n);
                checks++;
                if (d !== want) begin
                    fails++;
                    $display("[TB] FAIL rand_count it=%0d n=%0d: got %0d expected %0d", it, n, d, want);
                end
                peek(3'd0, d);
                want = {29'd0, ie, ar, model_en(ld, ar, p, n)};
                checks++;
                if (d !== want) begin
                    fails++;
                    $display("[TB] FAIL rand_ctrl it=%0d n=%0d: got %h expected %h", it, n, d, want);
                end
                peek(3'd3, d);
                checks++;
                if (d !== {31'd0, e}) begin
                    fails++;
                    $display("[TB] FAIL rand_status it=%0d n=%0d: got %h expected %0d", it, n, d, e);
                end
                checks++;
                if (Irq !== (e & ie)) begin
                    fails++;
                    $display("[TB] FAIL rand_irq it=%0d n=%0d: got %b expected %b", it, n, Irq, e & ie);
                end
                @(negedge Hclk);
            end
        end
        apb_write(3'd0, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            v = $urandom();
            apb_write(3'd1, v);
            apb_read(MY_SEL, 3'd1, d);
            checks++;
            if (d !== v) begin
                fails++;
                $display("[TB] FAIL b2b_load_%0d: got %h expected %h", i, d, v);
            end
        end
        v = $urandom() & 32'hFFFF_FFFE;
        apb_write(3'd0, v);
        apb_read(MY_SEL, 3'd0, d);
        checks++;
        if (d !== {29'd0, v[2:1], 1'b0}) begin
            fails++;
            $display("[TB] FAIL b2b_ctrl: got %h expected %h", d, {29'd0, v[2:1], 1'b0});
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        Hreset = 1'b1;
        bus_idle();
        repeat (3) @(negedge Hclk);
        Hreset = 1'b0;
        @(negedge Hclk);
        test_reset();
        test_one_shot();
        test_auto_reload_w1c();
        test_decode();
        test_prescaler();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
